clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel, runtime-programmable clock divider, replacing the single fixed-ratio divider. Each of NUM_CH channels has its own divisor and output mode. Each channel produces a one-cycle enable pulse (`tick`) and a divided output (`div_out`) from one board clock. A valid/ready configuration port changes divisors glitch-free: a new setting takes effect only on a period boundary. The block sits at top level and feeds downstream logic (display refresh, LED blink, slow-rate sequencers) in the clk_in domain.

## Interface
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 26: divisor/counter width in bits.
- DEF_DIV, 50000000: divisor loaded into every channel at reset (must fit in CNT_W).
- CH_W, $clog2(NUM_CH) (min 1): width of cfg_ch.

- clk_in  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accept; a transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_ch  in  CH_W  target channel index.
- cfg_div  in  CNT_W  new divisor D.
- cfg_mode  in  1  0 = toggle (square wave), 1 = pulse.
- tick  out  NUM_CH  registered one-cycle pulse at each channel terminal count.
- div_out  out  NUM_CH  registered divided output.
- cfg_pending  out  NUM_CH  shadow config waiting to commit, per channel.

## Operation
- Per-channel state:
  - counter cnt[CNT_W-1:0]
  - active divisor D and active mode M
  - shadow divisor/mode plus a pending flag
- Reset (rst=1 at an edge):
  - cnt=0, D=DEF_DIV, M=0, pending=0
  - tick=0, div_out=0
  - cfg_pending=0
- cfg_ready is combinational: !rst && !pending[cfg_ch], or 1 if cfg_ch >= NUM_CH.
- A transfer to cfg_ch >= NUM_CH is accepted and discarded.
- A transfer to a valid channel loads that channel's shadow registers and sets pending at the same edge.
- Channel counting when en=1, D≥1 and cnt < D-1: cnt increments, tick=0.
- Terminal count, when en=1, D≥1 and cnt == D-1:
  - cnt=0, tick=1.
  - div_out toggles when M=0; div_out=1 when M=1.
  - In pulse mode, div_out=0 at every non-terminal edge, so it mirrors tick.
- Disabled (en=0) or D=0:
  - cnt=0, tick=0.
  - div_out holds its value when M=0 and is forced to 0 when M=1.
- Commit: a pending shadow is copied to D/M and pending clears at an edge where either of these holds:
  - the channel hits terminal count (the new values govern the next period), or
  - the channel is disabled or its current D=0.
- When a commit changes M, div_out is forced to 0 at that edge. The tick of that terminal count is still issued.
- Commit and a new cfg transfer to the same channel in one cycle cannot occur, because cfg_ready is low while pending.
- Channels are fully independent. Simultaneous terminal counts on several channels are all honoured in the same cycle.
- Width rules:
  - cnt never exceeds D-1, and no overflow path exists.
  - Maximum D is 2^CNT_W-1.
  - D=1 gives tick stuck high and div_out toggling every cycle in toggle mode.

## Timing
- With ch_en going high at edge k and cnt=0, the first tick is visible after edge k+D-1. Ticks then repeat every D cycles.
- Toggle mode: div_out period 2·D cycles, 50% duty.
- Pulse mode: period D cycles, high for one cycle.
- Config latency, channel running: the new D applies from the period starting after the first terminal count following acceptance. The worst case is D_old cycles.
- Config latency, channel disabled or D=0: commit occurs at the edge after acceptance.
- Reset mid-operation:
  - all outputs return to 0 at the reset edge, and pending configs are discarded.
  - counting restarts from cnt=0 on the first non-reset edge with en=1.
- ch_en dropping mid-period: cnt clears at the next edge. A tick that was due in that cycle is not issued.

## Test plan
- Reset, then all ch_en=1 with NUM_CH=4, CNT_W=8, DEF_DIV=5 -> every channel ticks every 5 cycles, first tick 5 edges after en; div_out period 10 cycles, 50% duty.
- Write ch1 D=3, mode=0 while it is running at D=5 -> cfg_pending[1]=1 and cfg_ready low for ch1 until the next ch1 tick. Following intervals are 3 cycles, with no short or long pulse at the switch. Other channels are unaffected.
- Write ch2 D=2, mode=1 while ch2 is disabled -> commit the next edge. On enable, div_out[2]==tick[2], high 1 of every 2 cycles.
- D=0 on ch0, then D=1 -> with D=0 there are no ticks and div_out holds. With D=1, tick[0] is constantly 1 and div_out[0] toggles each cycle.
- Second cfg_valid to a pending channel -> not accepted. A cfg_ch=7 write with NUM_CH=4 -> accepted, with no state change.
- Assert rst for 1 cycle mid-period with a pending config -> tick/div_out/cfg_pending are 0 after the edge, D reverts to DEF_DIV, and the first tick comes DEF_DIV edges after rst falls.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers producing tick pulses and
// divided outputs; new divisors are shadowed and committed only on a period boundary.
module clk_div_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 50000000,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic ch_valid;
  logic sel_pending;

  assign ch_valid = 32'(cfg_ch) < NUM_CH;

  always_comb begin
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) sel_pending = cfg_pending[i];
    end
  end

  // Out-of-range channel writes are always accepted and simply dropped.
  assign cfg_ready = ch_valid ? (!rst && !sel_pending) : 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] div_reg;
      logic [CNT_W-1:0] shadow_div_reg;
      logic             mode_reg;
      logic             shadow_mode_reg;
      logic             pend_reg;
      logic             tick_reg;
      logic             out_reg;
      logic             run;
      logic             term;
      logic             load;
      logic             commit;

      assign run    = ch_en[gi] && (div_reg != '0);
      assign term   = run && (cnt_reg == div_reg - CNT_W'(1));
      assign load   = cfg_valid && cfg_ready && ch_valid && (cfg_ch == CH_W'(gi));
      // Idle channels have no period to protect, so they commit immediately.
      assign commit = pend_reg && (term || !run);

      always_ff @(posedge clk_in) begin
        if (rst) begin
          cnt_reg         <= '0;
          div_reg         <= CNT_W'(DEF_DIV);
          mode_reg        <= 1'b0;
          shadow_div_reg  <= '0;
          shadow_mode_reg <= 1'b0;
          pend_reg        <= 1'b0;
          tick_reg        <= 1'b0;
          out_reg         <= 1'b0;
        end else begin
          if (!run) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
            if (mode_reg) out_reg <= 1'b0;
          end else if (term) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
            out_reg  <= mode_reg ? 1'b1 : ~out_reg;
          end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            tick_reg <= 1'b0;
            if (mode_reg) out_reg <= 1'b0;
          end

          if (load) begin
            shadow_div_reg  <= cfg_div;
            shadow_mode_reg <= cfg_mode;
            pend_reg        <= 1'b1;
          end

          // A mode change restarts the output from low to avoid a stray level.
          if (commit) begin
            div_reg  <= shadow_div_reg;
            mode_reg <= shadow_mode_reg;
            pend_reg <= 1'b0;
            if (shadow_mode_reg != mode_reg) out_reg <= 1'b0;
          end
        end
      end

      assign tick[gi]        = tick_reg;
      assign div_out[gi]     = out_reg;
      assign cfg_pending[gi] = pend_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a per-cycle vector table for steady counting and a
// running reconfiguration, plus hand-written sequences for idle commits, D=0/1 and reset.
module tb_clk_div_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 5;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [3:0]       ch_en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [7:0]       cfg_div;
  logic             cfg_mode;
  logic [3:0]       tick;
  logic [3:0]       div_out;
  logic [3:0]       cfg_pending;

  logic [4:0]       ch_en5;
  logic             cfg_valid5;
  logic             cfg_ready5;
  logic [2:0]       cfg_ch5;
  logic [7:0]       cfg_div5;
  logic             cfg_mode5;
  logic [4:0]       tick5;
  logic [4:0]       div_out5;
  logic [4:0]       cfg_pending5;

  always #5 clk_in = ~clk_in;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_dut (
    .clk_in(clk_in), .rst(rst), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .tick(tick), .div_out(div_out), .cfg_pending(cfg_pending)
  );

  // Five channels give a 3-bit cfg_ch, so an index of 7 is expressible.
  clk_div_bank #(.NUM_CH(5), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_dut5 (
    .clk_in(clk_in), .rst(rst), .ch_en(ch_en5),
    .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5), .cfg_ch(cfg_ch5),
    .cfg_div(cfg_div5), .cfg_mode(cfg_mode5),
    .tick(tick5), .div_out(div_out5), .cfg_pending(cfg_pending5)
  );

  typedef struct {
    logic [3:0] en;
    logic       valid;
    logic [1:0] ch;
    logic [7:0] div;
    logic       mode;
    logic [3:0] exp_tick;
    logic [3:0] exp_dout;
    logic [3:0] exp_pend;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [25];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Steady counting at D=5: ticks at rows 1-10 every 5 edges, square wave of period 10.
    vecs[0]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[1]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[2]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[3]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[4]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'hF, 4'h0, 1'b1};
    vecs[5]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[6]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[7]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[8]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[9]  = '{4'hF, 1'b0, 2'd0, 8'd0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b1};
    // ch1 -> D=3 while running; the second write (D=9, pulse) must be refused.
    vecs[10] = '{4'hF, 1'b1, 2'd1, 8'd3, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0};
    vecs[11] = '{4'hF, 1'b1, 2'd1, 8'd9, 1'b1, 4'h0, 4'h0, 4'h2, 1'b0};
    vecs[12] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0};
    vecs[13] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0};
    vecs[14] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'hF, 4'hF, 4'h0, 1'b1};
    vecs[15] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[16] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[17] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h2, 4'hD, 4'h0, 1'b1};
    vecs[18] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'hD, 4'h0, 1'b1};
    vecs[19] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'hD, 4'h0, 4'h0, 1'b1};
    vecs[20] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h2, 4'h2, 4'h0, 1'b1};
    vecs[21] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'h2, 4'h0, 1'b1};
    vecs[22] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h0, 4'h2, 4'h0, 1'b1};
    vecs[23] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'h2, 4'h0, 4'h0, 1'b1};
    vecs[24] = '{4'hF, 1'b0, 2'd1, 8'd0, 1'b0, 4'hD, 4'hD, 4'h0, 1'b1};

    rst = 1'b1; ch_en = 4'h0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
    ch_en5 = 5'h0; cfg_valid5 = 1'b0; cfg_ch5 = 3'd0; cfg_div5 = 8'd0; cfg_mode5 = 1'b0;
    step();
    step();
    check("reset_tick", tick, 4'h0);
    check("reset_div_out", div_out, 4'h0);
    check("reset_pending", cfg_pending, 4'h0);
    check("reset_ready_low", cfg_ready, 1'b0);
    rst = 1'b0;
    step();
    check("post_reset_ready", cfg_ready, 1'b1);
    $display("reset released");

    // Out-of-range channel write on the 5-channel instance, then an idle-channel commit.
    cfg_ch5 = 3'd7; cfg_div5 = 8'd3; cfg_valid5 = 1'b1;
    #1;
    check("ch7_ready", cfg_ready5, 1'b1);
    step();
    check("ch7_no_pending", cfg_pending5, 5'h00);
    $display("cfg ch7 write pending=%b", cfg_pending5);
    cfg_ch5 = 3'd4;
    step();
    check("ch4_pending", cfg_pending5, 5'h10);
    check("ch4_ready_low", cfg_ready5, 1'b0);
    $display("cfg ch4 write pending=%b", cfg_pending5);
    cfg_valid5 = 1'b0;
    step();
    check("ch4_idle_commit", cfg_pending5, 5'h00);

    for (int v = 0; v < 25; v++) begin
      ch_en = vecs[v].en; cfg_valid = vecs[v].valid; cfg_ch = vecs[v].ch;
      cfg_div = vecs[v].div; cfg_mode = vecs[v].mode;
      step();
      check($sformatf("vec%0d_tick", v), tick, vecs[v].exp_tick);
      check($sformatf("vec%0d_div_out", v), div_out, vecs[v].exp_dout);
      check($sformatf("vec%0d_pending", v), cfg_pending, vecs[v].exp_pend);
      check($sformatf("vec%0d_ready", v), cfg_ready, vecs[v].exp_ready);
      $display("vec %0d tick=%b div_out=%b pend=%b ready=%b", v, tick, div_out, cfg_pending, cfg_ready);
    end

    // Disable ch0/ch2 (both holding div_out=1) and program ch2 D=2 pulse mode.
    ch_en = 4'b1010; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd2; cfg_mode = 1'b1;
    step();
    check("ch2_pending", cfg_pending, 4'h4);
    check("ch2_hold", div_out[2], 1'b1);
    check("ch0_hold", div_out[0], 1'b1);
    $display("cfg ch2 D=2 pulse pending=%b", cfg_pending);
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
    step();
    check("ch2_commit", cfg_pending, 4'h1);
    check("ch2_mode_change_low", div_out[2], 1'b0);
    $display("cfg ch0 D=0 pending=%b", cfg_pending);
    cfg_valid = 1'b0;
    step();
    check("ch0_commit", cfg_pending, 4'h0);
    ch_en = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("d0_tick_c%0d", k), tick[0], 1'b0);
      check($sformatf("d0_hold_c%0d", k), div_out[0], 1'b1);
      check($sformatf("pulse_tick_c%0d", k), tick[2], 1'((k % 2) == 0));
      check($sformatf("pulse_dout_c%0d", k), div_out[2], 1'((k % 2) == 0));
      $display("cycle %0d tick=%b div_out=%b", k, tick, div_out);
    end

    // ch0 D=0 -> D=1 commits on the next edge; then tick stuck high, div_out toggling.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_mode = 1'b0;
    step();
    check("d1_pending", cfg_pending[0], 1'b1);
    cfg_valid = 1'b0;
    step();
    check("d1_commit", cfg_pending[0], 1'b0);
    check("d1_commit_tick", tick[0], 1'b0);
    check("d1_commit_hold", div_out[0], 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("d1_tick_c%0d", k), tick[0], 1'b1);
      check($sformatf("d1_dout_c%0d", k), div_out[0], 1'((k % 2) == 0));
      $display("D=1 cycle %0d tick0=%b div_out0=%b", k, tick[0], div_out[0]);
    end

    // Reset with a pending config on ch3; everything restarts at DEF_DIV.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
    step();
    check("rst_pre_pending", cfg_pending[3], 1'b1);
    cfg_valid = 1'b0; rst = 1'b1;
    step();
    check("mid_rst_tick", tick, 4'h0);
    check("mid_rst_div_out", div_out, 4'h0);
    check("mid_rst_pending", cfg_pending, 4'h0);
    check("mid_rst_ready", cfg_ready, 1'b0);
    $display("mid reset tick=%b div_out=%b pend=%b", tick, div_out, cfg_pending);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("rst_tick_c%0d", k), tick, (k % 5 == 0) ? 4'hF : 4'h0);
      check($sformatf("rst_dout_c%0d", k), div_out, (k >= 5 && k <= 9) ? 4'hF : 4'h0);
      $display("post reset cycle %0d tick=%b div_out=%b", k, tick, div_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
